// File: rtl/xilinx_ip_pkg.sv
// Shared definitions for the Xilinx IP demo datapath: ROM feeder FSM
// encoding and default geometry of the ROM / FIFO write path.
package xilinx_ip_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } feeder_state_e;

    localparam int unsigned DefAddrW  = 6;
    localparam int unsigned DefDataW  = 16;
    localparam int unsigned DefDepth  = 64;
    localparam int unsigned DefRomLat = 1;

endpackage

// File: rtl/feeder_skid_buf.sv
// Small register-based synchronous FIFO that catches ROM words whose reads
// were already issued when the downstream FIFO stalled.
module feeder_skid_buf #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned WIDTH = 16
) (
    input  logic                         sys_clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;

    assign head = mem_q[rd_ptr_q];

    // Storage, circular pointers and occupancy; callers never pop when empty.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rom_fifo_feeder.sv
// Write-side sequencer: sweeps ROM addresses, absorbs ROM read latency and
// pushes every ROM word into the CDC FIFO exactly once, in order, while
// honouring FIFO full and write-side reset busy.
module rom_fifo_feeder
    import xilinx_ip_pkg::*;
#(
    parameter int unsigned ADDR_W     = DefAddrW,
    parameter int unsigned DATA_W     = DefDataW,
    parameter int unsigned DEPTH      = DefDepth,
    parameter int unsigned ROM_LAT    = DefRomLat,
    parameter int unsigned NUM_PASSES = 1
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout,
    input  logic              fifo_full,
    input  logic              fifo_wr_rst_busy,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_din,
    output logic              busy,
    output logic              done,
    output logic [15:0]       word_cnt
);

    // Room for every word in the ROM pipe plus one being written and one spare,
    // so issue never has to wait on a pop in steady state.
    localparam int unsigned SKID_DEPTH = ROM_LAT + 2;
    localparam int unsigned CntW       = $clog2(SKID_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
    localparam logic [15:0]       LastPass = 16'(NUM_PASSES - 1);

    feeder_state_e     state_q;
    logic [ROM_LAT-1:0] vld_q;
    logic [ROM_LAT-1:0] vld_d;
    logic [15:0]       pass_q;
    logic [CntW-1:0]   skid_cnt;
    logic [DATA_W-1:0] skid_head;
    logic              issue;
    logic              capture;
    logic              pop;
    logic              final_issue;
    logic              drain_empty;
    int unsigned       inflight;
    int unsigned       skid_cnt_nxt;

    // Issue/capture/pop decisions and the look-ahead emptiness used to leave DRAIN.
    always_comb begin
        inflight = 0;
        for (int unsigned i = 0; i < ROM_LAT; i++) begin
            inflight = inflight + 32'(vld_q[i]);
        end
        issue = (state_q == StRun) && !fifo_wr_rst_busy
                && ((inflight + 32'(skid_cnt)) < SKID_DEPTH);
        capture = vld_q[ROM_LAT-1];
        pop = (skid_cnt != '0) && !fifo_full && !fifo_wr_rst_busy;
        final_issue = issue && (NUM_PASSES != 0) && (rom_addr == LastAddr)
                      && (pass_q == LastPass);
        vld_d = (vld_q << 1) | ROM_LAT'(issue);
        skid_cnt_nxt = 32'(skid_cnt) + 32'(capture) - 32'(pop);
        // done is registered, so decide on what the buffers hold after this edge
        drain_empty = (vld_d == '0) && (skid_cnt_nxt == 0);
    end

    feeder_skid_buf #(
        .DEPTH (SKID_DEPTH),
        .WIDTH (DATA_W)
    ) u_skid (
        .sys_clk (sys_clk),
        .rst     (rst),
        .push    (capture),
        .pop     (pop),
        .din     (rom_dout),
        .head    (skid_head),
        .count   (skid_cnt)
    );

    assign fifo_wr_en = pop;
    assign fifo_din   = skid_head;

    // FSM with address/pass counters, ROM valid pipe and registered status outputs.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            vld_q    <= '0;
            pass_q   <= '0;
            rom_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            word_cnt <= '0;
        end else begin
            done  <= 1'b0;
            vld_q <= vld_d;
            if (pop) begin
                word_cnt <= word_cnt + 16'd1;
            end
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q  <= StRun;
                        busy     <= 1'b1;
                        rom_addr <= '0;
                        pass_q   <= '0;
                        word_cnt <= '0;
                    end
                end
                StRun: begin
                    if (issue) begin
                        if (rom_addr == LastAddr) begin
                            rom_addr <= '0;
                            pass_q   <= pass_q + 16'd1;
                        end else begin
                            rom_addr <= rom_addr + ADDR_W'(1);
                        end
                    end
                    if (stop || final_issue) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (drain_empty) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_fifo_feeder.sv
// Scoreboard bench for rom_fifo_feeder. Three instances cover the parameter
// sets (single pass, free-running, two-cycle ROM with two passes); the
// stimulus task predicts the written words and their cycles, a monitor on the
// falling edge pops and compares whatever the selected instance writes.
module tb_rom_fifo_feeder;

    localparam int unsigned AW  = 6;
    localparam int unsigned DW  = 16;
    localparam int unsigned DEP = 64;

    typedef struct {
        logic [15:0] data;
        int          cyc;   // -1: cycle not predicted
    } exp_t;

    logic          sys_clk = 1'b0;
    logic          rst;
    logic [2:0]    start_v;
    logic          stop;
    logic          fifo_full;
    logic          fifo_wr_rst_busy;

    logic [AW-1:0] addr_a, addr_b, addr_c;
    logic [DW-1:0] dout_a, dout_b, dout_c, dout_c1;
    logic          wr_a, wr_b, wr_c;
    logic [DW-1:0] din_a, din_b, din_c;
    logic          busy_a, busy_b, busy_c;
    logic          done_a, done_b, done_c;
    logic [15:0]   wc_a, wc_b, wc_c;

    int            sel;
    logic [AW-1:0] m_addr;
    logic          m_wr;
    logic [DW-1:0] m_din;
    logic          m_busy;
    logic          m_done;
    logic [15:0]   m_wc;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   t0 = 0;
    bit   mon_en = 0;
    bit   done_seen;
    int   done_cyc;
    int   wr_seen;
    int   issued;
    int   skid_max;
    int   exp_words;
    logic [AW-1:0] prev_addr;
    exp_t sb_q[$];

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // ROM models: word = addr*3; one register for latency 1, two for latency 2
    always @(posedge sys_clk) begin
        dout_a  <= 16'(32'(addr_a) * 3);
        dout_b  <= 16'(32'(addr_b) * 3);
        dout_c1 <= 16'(32'(addr_c) * 3);
        dout_c  <= dout_c1;
    end

    rom_fifo_feeder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .ROM_LAT(1), .NUM_PASSES(1)) u_a (
        .sys_clk (sys_clk), .rst (rst), .start (start_v[0]), .stop (stop),
        .rom_addr (addr_a), .rom_dout (dout_a), .fifo_full (fifo_full),
        .fifo_wr_rst_busy (fifo_wr_rst_busy), .fifo_wr_en (wr_a), .fifo_din (din_a),
        .busy (busy_a), .done (done_a), .word_cnt (wc_a)
    );

    rom_fifo_feeder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .ROM_LAT(1), .NUM_PASSES(0)) u_b (
        .sys_clk (sys_clk), .rst (rst), .start (start_v[1]), .stop (stop),
        .rom_addr (addr_b), .rom_dout (dout_b), .fifo_full (fifo_full),
        .fifo_wr_rst_busy (fifo_wr_rst_busy), .fifo_wr_en (wr_b), .fifo_din (din_b),
        .busy (busy_b), .done (done_b), .word_cnt (wc_b)
    );

    rom_fifo_feeder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .ROM_LAT(2), .NUM_PASSES(2)) u_c (
        .sys_clk (sys_clk), .rst (rst), .start (start_v[2]), .stop (stop),
        .rom_addr (addr_c), .rom_dout (dout_c), .fifo_full (fifo_full),
        .fifo_wr_rst_busy (fifo_wr_rst_busy), .fifo_wr_en (wr_c), .fifo_din (din_c),
        .busy (busy_c), .done (done_c), .word_cnt (wc_c)
    );

    always_comb begin
        case (sel)
            0: begin
                m_addr = addr_a; m_wr = wr_a; m_din = din_a;
                m_busy = busy_a; m_done = done_a; m_wc = wc_a;
            end
            1: begin
                m_addr = addr_b; m_wr = wr_b; m_din = din_b;
                m_busy = busy_b; m_done = done_b; m_wc = wc_b;
            end
            default: begin
                m_addr = addr_c; m_wr = wr_c; m_din = din_c;
                m_busy = busy_c; m_done = done_c; m_wc = wc_c;
            end
        endcase
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: required event did not occur", name);
    endtask

    // Monitor: pop the scoreboard on every write, watch outstanding words and done
    int   rel_m;
    exp_t e_m;
    always @(negedge sys_clk) begin
        if (mon_en) begin
            rel_m = cyc - t0;
            if (rel_m >= 2) begin
                if (m_addr != prev_addr) issued++;
                n_vec++;
                if (issued - wr_seen > skid_max) begin
                    n_err++;
                    $display("FAIL outstanding: got %0d, limit %0d", issued - wr_seen, skid_max);
                end
            end
            prev_addr = m_addr;
            if (m_wr) begin
                if (sb_q.size() == 0) begin
                    fail("extra_write");
                end else begin
                    e_m = sb_q.pop_front();
                    check("wr_data", int'(m_din), int'(e_m.data));
                    if (e_m.cyc >= 0) check("wr_cycle", rel_m, e_m.cyc);
                end
                wr_seen++;
            end
            if (m_done) begin
                if (!done_seen) begin
                    done_seen = 1;
                    done_cyc  = rel_m;
                    check("word_cnt_at_done", int'(m_wc), exp_words);
                end else begin
                    check("done_repeat", int'(m_done), 0);
                end
            end
        end
    end

    // One run: build expectations from throughput rules, then drive cycle by cycle.
    // Window bounds: fifo_full high in [full_lo, full_hi], wr_rst_busy in [0, rb_hi].
    task automatic run_scn(input int s, input int lat, input int n, input int full_lo,
                           input int full_hi, input int rb_hi, input int stop_at,
                           input bit rnd, input int rst_at);
        int   first_issue;
        int   c;
        int   last;
        int   nw;
        int   exp_done;
        exp_t e;
        first_issue = (rb_hi >= 1) ? rb_hi + 1 : 1;
        nw = (stop_at > 0) ? stop_at - first_issue + 1 : n;
        c = first_issue + lat + 1;
        last = c;
        for (int i = 0; i < nw; i++) begin
            while ((c >= full_lo && c <= full_hi) || c <= rb_hi) c++;
            e.data = 16'((i % DEP) * 3);
            e.cyc  = rnd ? -1 : c;
            sb_q.push_back(e);
            last = c;
            c++;
        end
        exp_done  = last + 1;
        exp_words = nw;
        skid_max  = lat + 2;
        done_seen = 0;
        done_cyc  = -1;
        wr_seen   = 0;
        issued    = 0;

        @(posedge sys_clk); #1;
        sel = s;
        t0 = cyc;
        start_v = '0;
        start_v[s] = 1'b1;
        fifo_full = (full_lo <= 0 && full_hi >= 0);
        fifo_wr_rst_busy = (rb_hi >= 0);
        stop = 1'b0;
        mon_en = 1;
        for (int rel = 1; rel <= 600; rel++) begin
            @(posedge sys_clk); #1;
            start_v = '0;
            fifo_full = rnd ? ($urandom_range(0, 2) == 0) : (rel >= full_lo && rel <= full_hi);
            fifo_wr_rst_busy = (rel <= rb_hi);
            stop = (rel == stop_at);
            if (rel == 1) begin
                check("busy_in_run", int'(m_busy), 1);
                check("addr_first_issue", int'(m_addr), 0);
            end
            if (rel == rst_at) begin
                mon_en = 0;
                #2 rst = 1'b1;
                #1;
                check("rst_addr", int'(m_addr), 0);
                check("rst_wr_en", int'(m_wr), 0);
                check("rst_din", int'(m_din), 0);
                check("rst_busy", int'(m_busy), 0);
                check("rst_done", int'(m_done), 0);
                check("rst_word_cnt", int'(m_wc), 0);
                @(posedge sys_clk); #1;
                rst = 1'b0;
                fifo_full = 1'b0;
                check("writes_before_rst", wr_seen, rst_at - lat - 2);
                sb_q.delete();
                for (int k = 0; k < 5; k++) begin
                    @(negedge sys_clk);
                    check("no_done_after_rst", int'(m_done), 0);
                end
                check("idle_after_rst", int'(m_busy), 0);
                return;
            end
            if (done_seen && rel > done_cyc) break;
        end
        mon_en = 0;
        fifo_full = 1'b0;
        fifo_wr_rst_busy = 1'b0;
        stop = 1'b0;
        if (!done_seen) begin
            fail("done_timeout");
        end else begin
            if (!rnd) check("done_cycle", done_cyc, exp_done);
            check("done_width", int'(m_done), 0);
            check("busy_after_done", int'(m_busy), 0);
        end
        check("words_missing", sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        int lo;
        rst = 1'b1;
        start_v = '0;
        stop = 1'b0;
        fifo_full = 1'b0;
        fifo_wr_rst_busy = 1'b0;
        sel = 0;
        repeat (2) @(posedge sys_clk);
        #1;
        check("reset_addr", int'(m_addr), 0);
        check("reset_wr_en", int'(m_wr), 0);
        check("reset_din", int'(m_din), 0);
        check("reset_busy", int'(m_busy), 0);
        check("reset_done", int'(m_done), 0);
        check("reset_word_cnt", int'(m_wc), 0);
        rst = 1'b0;

        // single pass, no back-pressure: writes 3..66, done 67
        run_scn(0, 1, 64, 0, -1, -1, 0, 0, -1);
        // fifo_full in 10..14, then a random stall window
        run_scn(0, 1, 64, 10, 14, -1, 0, 0, -1);
        lo = $urandom_range(4, 50);
        run_scn(0, 1, 64, lo, lo + $urandom_range(0, 7), -1, 0, 0, -1);
        // write-side reset busy through cycle 20
        run_scn(0, 1, 64, 0, -1, 20, 0, 0, -1);
        // free-running with stop at cycle 100 (wraps 63 -> 0)
        run_scn(1, 1, 0, 0, -1, -1, 100, 0, -1);
        // two-cycle ROM, two passes
        run_scn(2, 2, 128, 0, -1, -1, 0, 0, -1);
        // reset mid-run, then a clean replay from address 0
        run_scn(0, 1, 64, 0, -1, -1, 0, 0, 30);
        run_scn(0, 1, 64, 0, -1, -1, 0, 0, -1);
        // random back-pressure on the two-cycle ROM instance
        run_scn(2, 2, 128, 0, -1, -1, 0, 1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rom_fifo_feeder.md
# rom_fifo_feeder

Write-side sequencer for the clock-domain-crossing FIFO in the Xilinx IP demo datapath. It sits in the 50 MHz domain between the block-RAM ROM and the FIFO write port. It sweeps ROM addresses, absorbs the ROM read latency, and pushes each ROM word into the FIFO exactly once and in order. It honours `full` and `wr_rst_busy` without dropping or duplicating words.

## Interface
Parameters:
- `ADDR_W`, 6: ROM address width.
- `DATA_W`, 16: ROM/FIFO write data width.
- `DEPTH`, 64: words per pass; addresses 0..DEPTH-1, with DEPTH ≤ 2^ADDR_W.
- `ROM_LAT`, 1: ROM read latency in cycles (1 = no output register, 2 = output register); legal values 1 or 2.
- `NUM_PASSES`, 1: passes before auto-stop; 0 = run until `stop`.

Ports (one clock; reset is asynchronous and active-high):
- `sys_clk` in 1: clock, the 50 MHz write-domain clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request; honoured only in IDLE.
- `stop` in 1: single-cycle request; honoured only in RUN.
- `rom_addr` out ADDR_W: ROM address (registered).
- `rom_dout` in DATA_W: ROM read data.
- `fifo_full` in 1: FIFO full.
- `fifo_wr_rst_busy` in 1: FIFO write-side reset busy.
- `fifo_wr_en` out 1: FIFO write strobe.
- `fifo_din` out DATA_W: FIFO write data.
- `busy` out 1: high in RUN or DRAIN.
- `done` out 1: one-cycle pulse on the DRAIN→IDLE transition.
- `word_cnt` out 16: words written since the last `start`; wraps at 2^16.

## Operation
- **Reset values:** state IDLE; all of `rom_addr`, `fifo_wr_en`, `fifo_din`, `busy`, `done`, `word_cnt` are 0. In-flight words and skid contents are discarded.
- **IDLE → RUN** on `start`. On entry: `rom_addr`=0, pass counter=0, `word_cnt`=0.
- **Issue:** in RUN, an issue occurs when `!fifo_wr_rst_busy && (inflight + skid_cnt) < SKID_DEPTH`, where SKID_DEPTH = ROM_LAT+2.
  - Issue marks the current `rom_addr` as in flight in a ROM_LAT-deep valid shift register.
  - `rom_addr` then increments. At DEPTH-1 it wraps to 0 and the pass counter increments.
- **Capture:** when the valid shift register output is high, `rom_dout` is pushed into the skid buffer.
  - The skid buffer cannot overflow, because of the issue condition.
- **Pop:** `fifo_wr_en` = skid non-empty && `!fifo_full` && `!fifo_wr_rst_busy`. `fifo_din` = skid head.
  - Every pop increments `word_cnt`.
  - Push and pop in the same cycle are allowed.
- **RUN → DRAIN** when either:
  - `stop` is asserted, or
  - `NUM_PASSES` ≠ 0 and the final address of pass NUM_PASSES has issued.
  - No issue occurs in the transition cycle after the final address.
  - `stop` and a final issue in the same cycle: that issue completes, then DRAIN.
- **DRAIN:** no issues. Captures and pops continue.
  - When inflight==0 and the skid is empty: `done`=1 for one cycle, next state IDLE.
- `start` outside IDLE and `stop` outside RUN are ignored.
- `busy` = (state != IDLE), registered together with the state.

## Timing
- `start` sampled at edge 0 → RUN from cycle 1. First issue in cycle 1 with `rom_addr`=0.
- Issue in cycle c → captured at the end of cycle c+ROM_LAT → earliest `fifo_wr_en` in cycle c+ROM_LAT+1.
- Throughput is 1 word/cycle sustained while `fifo_full`=0 and `fifo_wr_rst_busy`=0.
- Under `fifo_full`: at most SKID_DEPTH words are outstanding. Issue resumes the cycle after a pop frees a slot.
- `fifo_wr_rst_busy` high: no issue and no pop. State and counters hold.
- `rst` mid-operation: returns to IDLE immediately (asynchronous); `done` is not pulsed.

## Structure
- The shared package/header `xilinx_ip_pkg` holds:
  - state encodings IDLE/RUN/DRAIN (2 bits);
  - defaults for DEPTH, ROM_LAT, ADDR_W, DATA_W.
- Sub-module `feeder_skid_buf`: a register-based synchronous FIFO.
  - Parameters: depth SKID_DEPTH, width DATA_W.
  - Signals: push, pop, head, count.
  - Reset: same asynchronous active-high `rst`.
- The top level holds the FSM, address/pass counters, in-flight shift register, and `word_cnt`.

## Test plan
1. ROM model word = addr*3, ROM_LAT=1, NUM_PASSES=1, `start` at cycle 0.
   - `fifo_wr_en` high in cycles 3..66 with data 0,3,…,189.
   - `done` in cycle 67; `word_cnt`=64.
2. As in scenario 1, with `fifo_full` forced high in cycles 10..14.
   - No `fifo_wr_en` during the stall.
   - At most 3 outstanding words.
   - Sequence is gap-free and in order; `word_cnt`=64; `done` 5 cycles later than scenario 1.
3. `fifo_wr_rst_busy` high in cycles 0..20, `start` at cycle 0.
   - First issue at cycle 21; first write at cycle 23.
   - Data correct; 64 words total.
4. NUM_PASSES=0, `stop` at cycle 100.
   - Addresses wrap 63→0.
   - Exactly the issued words are written (data continues 0,3,…,189,0,…).
   - `done` after the drain; `busy` low afterwards.
5. ROM_LAT=2, NUM_PASSES=2.
   - 128 writes in back-to-back cycles starting at cycle 4.
   - Second pass repeats the first pass data; `word_cnt`=128.
6. `rst` pulsed at cycle 30 of a run.
   - All outputs 0 immediately; no `done`.
   - A new `start` replays from address 0 with `word_cnt` restarting at 0.
